// File: rtl/ddr_arb_pkg.sv
// Shared types and widths for the four-client DDR round-robin arbiter.
package ddr_arb_pkg;

  localparam int unsigned NUM_CLIENTS = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BURST_W     = 8;
  localparam int unsigned BE_W        = DATA_W / 8;

  typedef logic [1:0] client_idx_t;

  typedef enum logic [1:0] {IDLE, GRANT, WR_BURST, RD_WAIT} arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               read;
    logic               write;
    logic [BURST_W-1:0] burstcnt;
    logic [BE_W-1:0]    byteenable;
  } ddr_cmd_t;

  // A burst count of zero behaves as a single beat.
  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/ddr_if.sv
// DDR command/data port; to_host faces the DDR adapter, from_host faces a client.
interface ddr_if;
  import ddr_arb_pkg::*;

  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]  rdata;
  logic               read;
  logic               write;
  logic [BURST_W-1:0] burstcnt;
  logic [BE_W-1:0]    byteenable;
  logic               acquire;
  logic               busy;
  logic               rdata_ready;

  modport to_host (
    output addr, wdata, read, write, burstcnt, byteenable, acquire,
    input  busy, rdata_ready, rdata
  );

  modport from_host (
    input  addr, wdata, read, write, burstcnt, byteenable, acquire,
    output busy, rdata_ready, rdata
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester strictly after last.
module rr_pick4
  import ddr_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic        found;
  client_idx_t cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_arbiter4.sv
// Burst-aware round-robin arbiter sharing one DDR host port among four clients,
// with optional multi-burst locking through acquire.
module ddr_arbiter4
  import ddr_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK_BURSTS = 16
)
(
  input logic     clk,
  input logic     reset_n,
  ddr_if.to_host   x,
  ddr_if.from_host c0,
  ddr_if.from_host c1,
  ddr_if.from_host c2,
  ddr_if.from_host c3
);

  localparam int unsigned LOCK_W = $clog2(MAX_LOCK_BURSTS + 2);

  arb_state_t              state, state_n;
  client_idx_t             grant, grant_n, last_grant, last_n;
  logic [BURST_W-1:0]      beats, beats_n, beats_dec, eff_bc;
  logic [LOCK_W-1:0]       lock_cnt, lock_n;
  ddr_cmd_t                cmd [NUM_CLIENTS];
  ddr_cmd_t                sel;
  logic [NUM_CLIENTS-1:0]  acq, req, busy, rdy;
  logic                    pick_valid, done, lock_ok, others, x_rd, x_wr;
  client_idx_t             pick_idx;

  assign cmd[0] = {c0.addr, c0.wdata, c0.read, c0.write, c0.burstcnt, c0.byteenable};
  assign cmd[1] = {c1.addr, c1.wdata, c1.read, c1.write, c1.burstcnt, c1.byteenable};
  assign cmd[2] = {c2.addr, c2.wdata, c2.read, c2.write, c2.burstcnt, c2.byteenable};
  assign cmd[3] = {c3.addr, c3.wdata, c3.read, c3.write, c3.burstcnt, c3.byteenable};
  assign acq    = {c3.acquire, c2.acquire, c1.acquire, c0.acquire};

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) req[i] = cmd[i].read | cmd[i].write | acq[i];
  end

  assign sel       = cmd[grant];
  assign eff_bc    = eff_burst(sel.burstcnt);
  assign beats_dec = (beats != '0) ? beats - BURST_W'(1) : '0;
  assign others    = |(req & ~(NUM_CLIENTS'(1) << grant));
  // lock_cnt holds the contended bursts already chained; the one finishing now is +1.
  assign lock_ok   = acq[grant] &&
                     (!others || (MAX_LOCK_BURSTS == 0) ||
                      (32'(lock_cnt) + 32'd1 < MAX_LOCK_BURSTS));

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Host-side command mux; strobes only pass while the grant is live.
  always_comb begin
    x_rd = 1'b0;
    x_wr = 1'b0;
    case (state)
      GRANT:    begin x_rd = sel.read; x_wr = sel.write; end
      WR_BURST: x_wr = sel.write;
      default:  ;
    endcase
  end

  assign x.addr       = sel.addr;
  assign x.wdata      = sel.wdata;
  assign x.burstcnt   = sel.burstcnt;
  assign x.byteenable = sel.byteenable;
  assign x.read       = x_rd;
  assign x.write      = x_wr;
  assign x.acquire    = |acq;

  // Client-side returns: only the granted client sees busy/rdata_ready from x.
  always_comb begin
    busy = '1;
    rdy  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (client_idx_t'(i) == grant) begin
        busy[i] = (state == GRANT || state == WR_BURST) ? x.busy : 1'b1;
        rdy[i]  = (state != IDLE) && x.rdata_ready;
      end
    end
  end

  assign c0.busy = busy[0];  assign c0.rdata_ready = rdy[0];  assign c0.rdata = x.rdata;
  assign c1.busy = busy[1];  assign c1.rdata_ready = rdy[1];  assign c1.rdata = x.rdata;
  assign c2.busy = busy[2];  assign c2.rdata_ready = rdy[2];  assign c2.rdata = x.rdata;
  assign c3.busy = busy[3];  assign c3.rdata_ready = rdy[3];  assign c3.rdata = x.rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 2'd3;
      beats      <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_n;
      beats      <= beats_n;
      lock_cnt   <= lock_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last_grant;
    beats_n = beats;
    lock_n  = lock_cnt;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n = pick_idx;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (sel.read && !x.busy) begin
          beats_n = eff_bc;
          state_n = RD_WAIT;
        end else if (sel.write && !x.busy) begin
          beats_n = eff_bc - BURST_W'(1);
          if (eff_bc == BURST_W'(1)) done = 1'b1;
          else                       state_n = WR_BURST;
        end else if (!req[grant]) begin
          state_n = IDLE;
          lock_n  = '0;
        end
      end
      WR_BURST: begin
        if (sel.write && !x.busy) begin
          beats_n = beats_dec;
          if (beats <= BURST_W'(1)) done = 1'b1;
        end
      end
      RD_WAIT: begin
        if (x.rdata_ready) begin
          beats_n = beats_dec;
          if (beats <= BURST_W'(1)) done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // End of burst: either chain under lock or release to the round robin.
    if (done) begin
      last_n = grant;
      if (lock_ok) begin
        state_n = GRANT;
        if (others && (lock_cnt != '1)) lock_n = lock_cnt + LOCK_W'(1);
      end else begin
        state_n = IDLE;
        lock_n  = '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_arbiter4.sv
// Directed bench for ddr_arbiter4: behavioural host and client models plus
// immediate-assertion checks in one linear stimulus sequence.
module tb_ddr_arbiter4;
  import ddr_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ddr_if xa ();
  ddr_if ca [4] ();
  ddr_if xb ();
  ddr_if cb [4] ();

  ddr_arbiter4 #(.MAX_LOCK_BURSTS(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .x(xa),
    .c0(ca[0]), .c1(ca[1]), .c2(ca[2]), .c3(ca[3])
  );

  ddr_arbiter4 #(.MAX_LOCK_BURSTS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .x(xb),
    .c0(cb[0]), .c1(cb[1]), .c2(cb[2]), .c3(cb[3])
  );

  int checks = 0;
  int errors = 0;

  function automatic int bc_eff(input logic [7:0] b);
    return (b == 8'd0) ? 1 : int'(b);
  endfunction

  // Client models for dut_a: issue reads/writes until the requested count is accepted.
  int         rd_req [4] = '{default: 0};
  int         wr_req [4] = '{default: 0};
  int         racc   [4] = '{default: 0};
  int         wacc   [4] = '{default: 0};
  int         rdy_cnt[4] = '{default: 0};
  logic [7:0] bc     [4] = '{default: 8'd1};
  logic [3:0] acq    = 4'b0;
  logic [3:0] c_racc, c_wacc, c_busy, c_rdy;

  for (genvar g = 0; g < 4; g++) begin : g_ca
    assign ca[g].addr       = 32'(g);
    assign ca[g].wdata      = 32'h1000 + 32'(g);
    assign ca[g].read       = racc[g] < rd_req[g];
    assign ca[g].write      = wacc[g] < wr_req[g];
    assign ca[g].burstcnt   = bc[g];
    assign ca[g].byteenable = 4'hF;
    assign ca[g].acquire    = acq[g];
    assign c_racc[g] = ca[g].read  & ~ca[g].busy;
    assign c_wacc[g] = ca[g].write & ~ca[g].busy;
    assign c_busy[g] = ca[g].busy;
    assign c_rdy[g]  = ca[g].rdata_ready;
  end

  // Host model for dut_a: returns burstcnt beats starting the cycle after acceptance.
  logic busy_a = 1'b0, tog_en = 1'b0, tog = 1'b0, rdy_a = 1'b0;
  int   pend_a = 0;
  assign xa.busy        = tog_en ? tog : busy_a;
  assign xa.rdata_ready = rdy_a;
  assign xa.rdata       = 32'hCAFEF00D;

  always @(posedge clk) begin
    tog    <= ~tog;
    rdy_a  <= (pend_a != 0);
    pend_a <= pend_a - ((pend_a != 0) ? 1 : 0) +
              ((xa.read && !xa.busy) ? bc_eff(xa.burstcnt) : 0);
  end

  int x_wr_acc = 0, x_rd_hi = 0, c2_busy_lo = 0, order_n = 0;
  int order_log [128];

  always @(posedge clk) begin
    if (xa.write && !xa.busy) x_wr_acc <= x_wr_acc + 1;
    if (xa.read)              x_rd_hi  <= x_rd_hi + 1;
    if (!c_busy[2])           c2_busy_lo <= c2_busy_lo + 1;
    for (int i = 0; i < 4; i++) begin
      if (c_racc[i]) racc[i]    <= racc[i] + 1;
      if (c_wacc[i]) wacc[i]    <= wacc[i] + 1;
      if (c_rdy[i])  rdy_cnt[i] <= rdy_cnt[i] + 1;
      if ((c_racc[i] || c_wacc[i]) && order_n < 128) begin
        order_log[order_n] <= i;
        order_n            <= order_n + 1;
      end
    end
  end

  // dut_b (unlimited lock): only c0 and c3 are active, single-beat reads.
  int   b_req0 = 0, b_acc0 = 0, b_req3 = 0, b_acc3 = 0, pend_b = 0;
  logic b_acq3 = 1'b0, rdy_b = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_cb
    assign cb[g].addr       = '0;
    assign cb[g].wdata      = '0;
    assign cb[g].write      = 1'b0;
    assign cb[g].burstcnt   = 8'd1;
    assign cb[g].byteenable = '0;
    assign cb[g].read       = (g == 0) ? (b_acc0 < b_req0) : (g == 3) ? (b_acc3 < b_req3) : 1'b0;
    assign cb[g].acquire    = (g == 3) ? b_acq3 : 1'b0;
  end

  assign xb.busy        = 1'b0;
  assign xb.rdata_ready = rdy_b;
  assign xb.rdata       = '0;

  always @(posedge clk) begin
    rdy_b  <= (pend_b != 0);
    pend_b <= pend_b - ((pend_b != 0) ? 1 : 0) + ((xb.read && !xb.busy) ? 1 : 0);
    if (cb[0].read && !cb[0].busy) b_acc0 <= b_acc0 + 1;
    if (cb[3].read && !cb[3].busy) b_acc3 <= b_acc3 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int s0, s1, s2, s3, sw, sr, sn;
  int sa [4];

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_read",  64'(xa.read),  64'd0);
    chk("rst_write", 64'(xa.write), 64'd0);
    chk("rst_busy",  64'(c_busy),   64'hF);
    chk("rst_rdy",   64'(c_rdy),    64'h0);
    chk("rst_last",  64'(dut_a.last_grant), 64'd3);
    chk("rst_state", 64'(dut_a.state), 64'(IDLE));
    reset_n = 1'b1;
    @(negedge clk);

    // c0 and c2 request 4-beat reads together; c0 wins after reset.
    bc[0] = 8'd4; bc[2] = 8'd4; rd_req[0] = 1; rd_req[2] = 1;
    for (int k = 0; k < 200 && rdy_cnt[0] != 4; k++) @(negedge clk);
    chk("t1_c0_beats",  64'(rdy_cnt[0]), 64'd4);
    chk("t1_c2_wait",   64'(racc[2]),    64'd0);
    chk("t1_c2_busy",   64'(c2_busy_lo), 64'd0);
    chk("t1_idle_gap",  64'(xa.read),    64'd0);
    @(negedge clk);
    chk("t1_c2_read",   64'(xa.read),    64'd1);
    chk("t1_c2_addr",   64'(xa.addr),    64'd2);
    for (int k = 0; k < 200 && rdy_cnt[2] != 4; k++) @(negedge clk);
    @(negedge clk);
    chk("t1_c2_beats",  64'(rdy_cnt[2]), 64'd4);
    chk("t1_last",      64'(dut_a.last_grant), 64'd2);
    chk("t1_c0_exact",  64'(rdy_cnt[0]), 64'd4);
    chk("t1_bcast",     64'(ca[3].rdata), 64'hCAFEF00D);

    // c1 8-beat write with x.busy toggling.
    sw = x_wr_acc; sr = x_rd_hi;
    bc[1] = 8'd8; tog_en = 1'b1; wr_req[1] = 8;
    for (int k = 0; k < 200 && (x_wr_acc - sw) < 7; k++) @(negedge clk);
    chk("t2_hold_at7",  64'(xa.write), 64'd1);
    for (int k = 0; k < 200 && (x_wr_acc - sw) < 8; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t2_beats",     64'(x_wr_acc - sw), 64'd8);
    chk("t2_no_read",   64'(x_rd_hi - sr),  64'd0);
    chk("t2_released",  64'(c_busy[1]),     64'd1);
    tog_en = 1'b0;

    // c3 chains under acquire while c0 waits: 16 bursts then c0.
    s0 = racc[0]; s3 = racc[3];
    bc[0] = 8'd1; bc[3] = 8'd1; acq[3] = 1'b1;
    rd_req[3] += 20; rd_req[0] += 1;
    for (int k = 0; k < 1000 && racc[0] == s0; k++) @(negedge clk);
    chk("t3_c0_served", 64'(racc[0] - s0), 64'd1);
    chk("t3_lock16",    64'(racc[3] - s3), 64'd16);
    for (int k = 0; k < 1000 && (racc[3] - s3) < 20; k++) @(negedge clk);
    chk("t3_all20",     64'(racc[3] - s3), 64'd20);
    acq[3] = 1'b0;
    repeat (3) @(negedge clk);

    // Unlimited lock: c3 finishes all 20 and keeps the port until acquire drops.
    b_acq3 = 1'b1; b_req3 = 20;
    repeat (2) @(negedge clk);
    b_req0 = 1;
    for (int k = 0; k < 1000 && b_acc3 < 20; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("t3b_all20",    64'(b_acc3), 64'd20);
    chk("t3b_c0_wait",  64'(b_acc0), 64'd0);
    b_acq3 = 1'b0;
    for (int k = 0; k < 100 && b_acc0 < 1; k++) @(negedge clk);
    chk("t3b_c0_after", 64'(b_acc0), 64'd1);

    // All four request single-beat reads: strict rotation 0,1,2,3,0,...
    sn = order_n;
    for (int i = 0; i < 4; i++) begin
      sa[i] = racc[i];
      bc[i] = 8'd1;
      rd_req[i] += 2;
    end
    for (int k = 0; k < 500 && (order_n - sn) < 8; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) chk("t4_order", 64'(order_log[sn + k]), 64'(k % 4));
    for (int i = 0; i < 4; i++) chk("t4_share", 64'(racc[i] - sa[i]), 64'd2);

    // Reset in RD_WAIT after 2 of 4 beats; late beats must reach nobody.
    s1 = rdy_cnt[1];
    bc[1] = 8'd4; rd_req[1] += 1;
    for (int k = 0; k < 200 && (rdy_cnt[1] - s1) < 2; k++) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_busy",      64'(c_busy),  64'hF);
    chk("t5_read",      64'(xa.read), 64'd0);
    chk("t5_rdy",       64'(c_rdy),   64'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_dropped",   64'(rdy_cnt[1] - s1), 64'd2);
    s2 = racc[2]; s3 = rdy_cnt[2];
    bc[2] = 8'd1; rd_req[2] += 1;
    for (int k = 0; k < 200 && (rdy_cnt[2] - s3) < 1; k++) @(negedge clk);
    chk("t5_regrant",   64'(racc[2] - s2),    64'd1);
    chk("t5_regrant_rdy", 64'(rdy_cnt[2] - s3), 64'd1);

    // burstcnt 0 write is one beat, then straight back to IDLE.
    sw = x_wr_acc;
    bc[2] = 8'd0; wr_req[2] += 1;
    for (int k = 0; k < 200 && (x_wr_acc - sw) < 1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t6_one_beat",  64'(x_wr_acc - sw), 64'd1);
    chk("t6_idle",      64'(dut_a.state),   64'(IDLE));
    chk("t6_busy",      64'(c_busy[2]),     64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
